// File: rtl/shift_add_ctrl.sv
// shift_add_ctrl: sequential shift-and-add unsigned multiplier.
//
// Ports
//   clk        : clock. All state updates on the rising edge.
//   rst_n      : asynchronous active-low reset.
//   din_valid  : operand pair offered on mult_a / mult_b.
//   din_ready  : high only in IDLE. The block can take an operand pair.
//   mult_a     : multiplicand, unsigned, WIDTH bits.
//   mult_b     : multiplier, unsigned, WIDTH bits.
//   dout_valid : high only in DONE. dout holds the finished product.
//   dout_ready : the consumer takes the product.
//   dout       : product, 2*WIDTH bits. Outside DONE it keeps the last completed product.
//   busy       : high in CALC or DONE.
//   state_dbg  : current FSM state (0 IDLE, 1 CALC, 2 DONE).
//
// Handshake
//   A transfer happens on a rising edge where valid and ready are both high.
//   A producer that raises valid keeps the data stable until that edge.
//   The input side accepts one pair and then stays closed until the product has been taken.
//   So there is always at least one IDLE cycle between two products.
module shift_add_ctrl #(
    parameter int WIDTH      = 4,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [WIDTH-1:0]     mult_a,
    input  logic [WIDTH-1:0]     mult_b,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [2*WIDTH-1:0]   dout,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic [WIDTH-1:0]   b_shift;
    logic               rest_zero;
    logic               last_step;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_sum;

    assign accept = din_valid && (state == IDLE);

    // b_shift[0] is the multiplier bit handled this cycle.
    // The bits above it tell us whether any work is left.
    assign b_shift   = b_reg >> cnt;
    assign rest_zero = ((b_shift >> 1) == '0);
    assign last_step = (cnt == CW'(WIDTH - 1)) || (EARLY_TERM && rest_zero);

    assign partial = b_shift[0] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0;
    assign acc_sum = acc + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (din_valid)  state_nxt = CALC;
            CALC: if (last_step)  state_nxt = DONE;
            DONE: if (dout_ready) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    assign din_ready  = (state == IDLE);
    assign dout_valid = (state == DONE);
    assign busy       = (state == CALC) || (state == DONE);
    assign state_dbg  = state;

    // Datapath. The operand registers only load in IDLE.
    // Traffic on the input side during CALC/DONE is therefore ignored.
    // The counter stops on the last step, so it never wraps.
    // This matters when WIDTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else if (accept) begin
            a_reg <= mult_a;
            b_reg <= mult_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == CALC) begin
            acc <= acc_sum;
            if (last_step) begin
                dout <= acc_sum;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Bench for shift_add_ctrl with WIDTH=4.
// Two instances are driven from the same inputs:
//   u_fix   : EARLY_TERM=0
//   u_early : EARLY_TERM=1
module tb_shift_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       din_valid;
    logic [3:0] mult_a;
    logic [3:0] mult_b;
    logic       dout_ready;

    logic       din_ready0, din_ready1;
    logic       dout_valid0, dout_valid1;
    logic [7:0] dout0, dout1;
    logic       busy0, busy1;
    logic [1:0] state0, state1;

    int errors;
    int checks;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        int         calc1;
        int         stall;
    } vec_t;

    vec_t vecs[10];

    shift_add_ctrl #(.WIDTH(4), .EARLY_TERM(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready0),
        .mult_a(mult_a), .mult_b(mult_b), .dout_valid(dout_valid0),
        .dout_ready(dout_ready), .dout(dout0), .busy(busy0), .state_dbg(state0)
    );

    shift_add_ctrl #(.WIDTH(4), .EARLY_TERM(1'b1)) u_early (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready1),
        .mult_a(mult_a), .mult_b(mult_b), .dout_valid(dout_valid1),
        .dout_ready(dout_ready), .dout(dout1), .busy(busy1), .state_dbg(state1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // A product transfers on the posedge that follows a negedge seeing valid&ready.
    always @(negedge clk) begin
        if (rst_n && dout_valid0 && dout_ready) begin
            if (exp_q0.size() == 0) begin
                check("fix_unexpected_output", 32'(dout0), 32'hFFFF_FFFF);
            end else begin
                check("fix_product", 32'(dout0), 32'(exp_q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dout_valid1 && dout_ready) begin
            if (exp_q1.size() == 0) begin
                check("early_unexpected_output", 32'(dout1), 32'hFFFF_FFFF);
            end else begin
                check("early_product", 32'(dout1), 32'(exp_q1.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!(din_ready0 && din_ready1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        if (!ok) check("idle_timeout", 32'(n), 32'd0);
    endtask

    // One operation.
    // exp_c1 is the expected number of CALC cycles for the early-terminating instance.
    // The product is held for `stall` extra cycles with dout_ready low.
    // `poke` pulses a second operand pair while both instances are calculating.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p,
                         input int exp_c1, input int stall, input bit poke);
        int c0, c1, n;
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        mult_a     = a;
        mult_b     = b;
        exp_q0.push_back(exp_p);
        exp_q1.push_back(exp_p);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        mult_a    = 4'($urandom_range(15, 0));
        mult_b    = 4'($urandom_range(15, 0));
        c0 = 0;
        c1 = 0;
        n  = 0;
        while (!(dout_valid0 && dout_valid1) && n < 40) begin
            @(negedge clk);
            if (poke && n == 0) begin
                din_valid = 1'b1;
                mult_a    = 4'd1;
                mult_b    = 4'd1;
            end else begin
                din_valid = 1'b0;
            end
            if (busy0 && !dout_valid0) c0++;
            if (busy1 && !dout_valid1) c1++;
            n++;
        end
        din_valid = 1'b0;
        if (n >= 40) begin
            check("done_timeout", 32'(n), 32'd0);
            return;
        end
        check("calc_cycles_fix", 32'(c0), 32'd4);
        check("calc_cycles_early", 32'(c1), 32'(exp_c1));
        @(posedge clk);
        #1;
        for (int i = 0; i < stall; i++) begin
            check("stall_valid_fix", 32'(dout_valid0), 32'd1);
            check("stall_valid_early", 32'(dout_valid1), 32'd1);
            check("stall_dout_fix", 32'(dout0), 32'(exp_p));
            check("stall_dout_early", 32'(dout1), 32'(exp_p));
            check("stall_din_ready", 32'({din_ready0, din_ready1}), 32'd0);
            @(posedge clk);
            #1;
        end
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        check("back_to_idle", 32'({din_ready0, din_ready1, dout_valid0, dout_valid1}), 32'b1100);
        check("dout_hold_fix", 32'(dout0), 32'(exp_p));
        check("dout_hold_early", 32'(dout1), 32'(exp_p));
    endtask

    // ---------------- test ----------------
    initial begin
        int bc, n, m;
        bit ok;
        logic [7:0] p;
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        mult_a     = 4'd0;
        mult_b     = 4'd0;
        dout_ready = 1'b0;

        vecs[0] = '{a: 4'd13, b: 4'd11, prod: 8'd143, calc1: 4, stall: 0};
        vecs[1] = '{a: 4'd15, b: 4'd15, prod: 8'd225, calc1: 4, stall: 0};
        vecs[2] = '{a: 4'd9,  b: 4'd0,  prod: 8'd0,   calc1: 1, stall: 1};
        vecs[3] = '{a: 4'd7,  b: 4'd2,  prod: 8'd14,  calc1: 2, stall: 0};
        vecs[4] = '{a: 4'd6,  b: 4'd5,  prod: 8'd30,  calc1: 3, stall: 3};
        vecs[5] = '{a: 4'd1,  b: 4'd8,  prod: 8'd8,   calc1: 4, stall: 0};
        vecs[6] = '{a: 4'd0,  b: 4'd5,  prod: 8'd0,   calc1: 3, stall: 2};
        vecs[7] = '{a: 4'd3,  b: 4'd1,  prod: 8'd3,   calc1: 1, stall: 0};
        vecs[8] = '{a: 4'd15, b: 4'd4,  prod: 8'd60,  calc1: 3, stall: 1};
        vecs[9] = '{a: 4'd11, b: 4'd9,  prod: 8'd99,  calc1: 4, stall: 0};

        // Reset state.
        #12;
        check("rst_dout", 32'({dout0, dout1}), 32'd0);
        check("rst_flags", 32'({din_ready0, din_ready1, dout_valid0, dout_valid1, busy0, busy1}), 32'b110000);
        check("rst_state", 32'({state0, state1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].calc1, vecs[i].stall, 1'b0);
        end

        // 13*11 with dout_ready held high.
        // Busy stays high for 4 CALC cycles plus 1 DONE cycle.
        wait_idle(ok);
        dout_ready = 1'b1;
        din_valid  = 1'b1;
        mult_a     = 4'd13;
        mult_b     = 4'd11;
        exp_q0.push_back(8'd143);
        exp_q1.push_back(8'd143);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        bc = 0;
        n  = 0;
        do begin
            @(negedge clk);
            if (busy0) bc++;
            n++;
        end while (busy0 && n < 30);
        check("busy_cycles_fix", 32'(bc), 32'd5);
        dout_ready = 1'b0;

        // A second operand pair offered during CALC must be ignored.
        do_op(4'd3, 4'd3, 8'd9, 2, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("no_second_op", 32'({busy0, busy1, dout_valid0, dout_valid1}), 32'd0);

        // Reset in the middle of 12*10, at cnt=2.
        wait_idle(ok);
        din_valid = 1'b1;
        mult_a    = 4'd12;
        mult_b    = 4'd10;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'({busy0, busy1}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", 32'({dout0, dout1}), 32'd0);
        check("midrst_flags", 32'({din_ready0, din_ready1, dout_valid0, dout_valid1, busy0, busy1}), 32'b110000);
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_valid", 32'({dout_valid0, dout_valid1}), 32'd0);
        end
        rst_n = 1'b1;
        do_op(4'd2, 4'd3, 8'd6, 2, 0, 1'b0);

        // Exhaustive sweep with random stalls.
        // The reference model is the arithmetic product.
        // For the early instance, the CALC-cycle count is the MSB index plus one.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                p = 8'(a * b);
                m = 0;
                for (int k = 0; k < 4; k++) if (((b >> k) & 1) == 1) m = k;
                do_op(4'(a), 4'(b), p, m + 1, int'($urandom_range(2, 0)), 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        check("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
